// File: rtl/pid_sample_sched.sv
// pid_sample_sched
// Sample-rate scheduler for the servo PID datapath. A period counter produces
// a one-cycle sample tick; a small FSM runs the ADC start/done handshake,
// latches position and reference, strobes the PID, waits out its pipeline,
// and converts Yk into a saturated PWM duty word plus a direction bit.
module pid_sample_sched #(
    parameter int cant_bits = 13,
    parameter int PERIOD    = 50000,
    parameter int PID_LAT   = 6,
    parameter int ADC_TMO   = 1000,
    parameter int SHIFT     = 8,
    parameter int DUTY_BITS = 10
) (
    input  logic                   Clk_G,
    input  logic                   Rst_G,
    input  logic                   Enable,
    input  logic                   Clr_Flags,
    output logic                   Adc_Start,
    input  logic                   Adc_Done,
    input  logic [cant_bits-1:0]   Adc_Data,
    input  logic [cant_bits-1:0]   Ref_In,
    output logic [cant_bits-1:0]   Pot,
    output logic [cant_bits-1:0]   Ref,
    output logic                   Rx_En,
    input  logic [2*cant_bits-1:0] Yk,
    output logic [DUTY_BITS-1:0]   Duty,
    output logic                   Dir,
    output logic                   Duty_Valid,
    output logic                   Overrun,
    output logic                   Timeout
);

    localparam int YW = 2 * cant_bits;
    localparam int PW = $clog2(PERIOD);
    localparam int TW = $clog2(ADC_TMO + 1);
    localparam int LW = $clog2(PID_LAT + 1);

    localparam logic [PW-1:0]        PERIOD_LAST   = PW'(PERIOD - 1);
    localparam logic [TW-1:0]        TMO_LAST      = TW'(ADC_TMO - 1);
    localparam logic [LW-1:0]        LAT_LAST      = LW'(PID_LAT - 1);
    localparam logic [DUTY_BITS-1:0] DUTY_MAX      = '1;
    localparam logic [YW:0]          DUTY_MAX_WIDE = (YW + 1)'((1 << DUTY_BITS) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_ADC_REQ,
        S_ADC_WAIT,
        S_FIRE,
        S_WAIT_PID,
        S_CAPTURE
    } state_t;

    state_t                 state;
    logic [PW-1:0]          period_cnt;
    logic [TW-1:0]          tmo_cnt;
    logic [LW-1:0]          lat_cnt;
    logic                   tick;
    logic [YW:0]            yk_wide;
    logic [YW:0]            yk_mag;
    logic [YW:0]            yk_shr;
    logic [DUTY_BITS-1:0]   duty_next;

    // Sample tick: the last count of the period while scheduling is enabled.
    assign tick = Enable && (period_cnt == PERIOD_LAST);

    // Period counter; held at zero while disabled so the first tick lands a full period after Enable rises.
    always_ff @(posedge Clk_G or posedge Rst_G) begin
        if (Rst_G) begin
            period_cnt <= '0;
        end else if (!Enable) begin
            period_cnt <= '0;
        end else if (period_cnt == PERIOD_LAST) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    // Yk to duty: magnitude in one extra bit so the most negative Yk cannot overflow, scale, then saturate.
    always_comb begin
        yk_wide   = {Yk[YW-1], Yk};
        yk_mag    = yk_wide[YW] ? (-yk_wide) : yk_wide;
        yk_shr    = yk_mag >> SHIFT;
        duty_next = (yk_shr > DUTY_MAX_WIDE) ? DUTY_MAX : yk_shr[DUTY_BITS-1:0];
    end

    // Sample sequencer with registered strobes, latched PID operands, duty output and sticky flags.
    always_ff @(posedge Clk_G or posedge Rst_G) begin
        if (Rst_G) begin
            state      <= S_IDLE;
            tmo_cnt    <= '0;
            lat_cnt    <= '0;
            Adc_Start  <= 1'b0;
            Rx_En      <= 1'b0;
            Duty_Valid <= 1'b0;
            Pot        <= '0;
            Ref        <= '0;
            Duty       <= '0;
            Dir        <= 1'b0;
            Overrun    <= 1'b0;
            Timeout    <= 1'b0;
        end else begin
            Adc_Start  <= 1'b0;
            Rx_En      <= 1'b0;
            Duty_Valid <= 1'b0;

            // The clear is written first so any set event below overrides it.
            if (Clr_Flags) begin
                Overrun <= 1'b0;
                Timeout <= 1'b0;
            end

            // A tick arriving mid-sample is dropped; only the flag remembers it.
            if (tick && (state != S_IDLE) && (state != S_WAIT_TICK)) begin
                Overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (Enable) begin
                        state <= S_WAIT_TICK;
                    end
                end

                S_WAIT_TICK: begin
                    if (tick) begin
                        state     <= S_ADC_REQ;
                        Adc_Start <= 1'b1;
                        tmo_cnt   <= '0;
                    end else if (!Enable) begin
                        state <= S_IDLE;
                    end
                end

                S_ADC_REQ: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    state   <= S_ADC_WAIT;
                end

                S_ADC_WAIT: begin
                    if (Adc_Done) begin
                        Pot     <= Adc_Data;
                        Ref     <= Ref_In;
                        Rx_En   <= 1'b1;
                        lat_cnt <= '0;
                        state   <= S_FIRE;
                    end else if (tmo_cnt >= TMO_LAST) begin
                        Timeout <= 1'b1;
                        state   <= S_WAIT_TICK;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                S_FIRE: begin
                    lat_cnt <= lat_cnt + LW'(1);
                    state   <= (PID_LAT == 1) ? S_CAPTURE : S_WAIT_PID;
                end

                S_WAIT_PID: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= S_CAPTURE;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end

                S_CAPTURE: begin
                    Duty       <= duty_next;
                    Dir        <= Yk[YW-1];
                    Duty_Valid <= 1'b1;
                    state      <= Enable ? S_WAIT_TICK : S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
